// File: rtl/uart_rx_framed_if.sv
// Received-word handshake bundle for uart_rx_framed.
//   data_out   : received word (first bit on the line lands in bit 0)
//   data_valid : data_out and the error flags are valid; held until accepted
//   data_ready : consumer acceptance; transfer when data_valid & data_ready
//   parity_err : parity mismatch for the presented word
//   frame_err  : a stop bit was sampled 0 for the presented word
//   overrun    : sticky, a frame was dropped while data_valid was pending
// master = receiver side, slave = consumer side.
interface uart_rx_framed_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;

  modport master (
    output data_out, data_valid, parity_err, frame_err, overrun,
    input  data_ready
  );

  modport slave (
    input  data_out, data_valid, parity_err, frame_err, overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_rx_framed.sv
// UART receiver with optional parity, 1/2 stop bits and a valid/ready output.
//   clk     : single clock, rising edge
//   reset_n : asynchronous active-low reset
//   rx      : asynchronous serial line, idle high
//   rx_if   : received word, flags and handshake (master side)
// Start bit is re-checked at mid-bit; every later bit is sampled one full bit
// period after the previous sample. The word is presented on the edge of the
// last stop sample, so the rest of that stop bit is not waited out.
module uart_rx_framed #(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  uart_rx_framed_if.master rx_if
);
  localparam int BIT_CNT = CLOCK_RATE / BAUD_RATE;
  localparam int HALF    = BIT_CNT / 2;
  localparam int CW      = $clog2(BIT_CNT) + 1;

  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1    = CW'(BIT_CNT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY == 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic                 rx_meta_q, rx_sync_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  // Set when a frame ends on a low line (break): no new start until rx is high.
  logic                 wait_hi_q, wait_hi_d;
  logic                 done;

  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic                 dv_q, dv_d, pe_q, pe_d, fe_q, fe_d, ov_q, ov_d;
  logic                 bit_tick, hs;

  assign bit_tick = (cnt_q == BIT_M1);
  assign hs       = dv_q & rx_if.data_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      wait_hi_q <= 1'b0;
      dout_q    <= '0;
      dv_q      <= 1'b0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      wait_hi_q <= wait_hi_d;
      dout_q    <= dout_d;
      dv_q      <= dv_d;
      pe_q      <= pe_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    wait_hi_d = wait_hi_q & ~rx_sync_q;
    done      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (!rx_sync_q && !wait_hi_q) state_d = S_START;
      end
      S_START: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == HALF_M1) begin
          cnt_d   = '0;
          state_d = rx_sync_q ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 4'd1;
          if (idx_q == LAST_DATA) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_tick) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rx_sync_q) != ODD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_q + 1'b1;
        if (bit_tick) begin
          cnt_d = '0;
          idx_d = idx_q + 4'd1;
          if (!rx_sync_q) ferr_d = 1'b1;
          if (idx_q == LAST_STOP) begin
            done      = 1'b1;
            state_d   = S_IDLE;
            wait_hi_d = ~rx_sync_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output word: ferr_d already folds in the stop sample taken this cycle.
  always_comb begin
    dout_d = dout_q;
    dv_d   = dv_q;
    pe_d   = pe_q;
    fe_d   = fe_q;
    ov_d   = ov_q;
    if (hs) begin
      dv_d = 1'b0;
      ov_d = 1'b0;
    end
    if (done) begin
      if (!dv_q || rx_if.data_ready) begin
        dout_d = shift_q;
        pe_d   = perr_q;
        fe_d   = ferr_d;
        dv_d   = 1'b1;
      end else begin
        ov_d = 1'b1;
      end
    end
  end

  assign rx_if.data_out   = dout_q;
  assign rx_if.data_valid = dv_q;
  assign rx_if.parity_err = pe_q;
  assign rx_if.frame_err  = fe_q;
  assign rx_if.overrun    = ov_q;
endmodule

// File: tb/tb_uart_rx_framed.sv
// Bench for uart_rx_framed at 16 clocks per bit: dut_a is 8N1, dut_b is 7E2.
// A negedge monitor logs every rising data_valid with its cycle and payload;
// expectations come from frame contents and the latency formula.
module tb_uart_rx_framed;
  localparam int BC    = 16;
  localparam int HF    = 8;
  localparam int LAT_A = HF + 9 * BC;   // 8 data + 1 stop
  localparam int LAT_B = HF + 10 * BC;  // 7 data + parity + 2 stop
  localparam int SYNC  = 3;             // line edge to START entry

  typedef struct {
    int         t;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n;
  logic rx_a, rx_b;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   hi_a = 0;
  logic dva_p = 1'b0, dvb_p = 1'b0;
  rec_t qa[$];
  rec_t qb[$];

  uart_rx_framed_if #(.DATA_BITS(8)) if_a ();
  uart_rx_framed_if #(.DATA_BITS(7)) if_b ();

  uart_rx_framed #(.CLOCK_RATE(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
    dut_a (.clk(clk), .reset_n(reset_n), .rx(rx_a), .rx_if(if_a));
  uart_rx_framed #(.CLOCK_RATE(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2))
    dut_b (.clk(clk), .reset_n(reset_n), .rx(rx_b), .rx_if(if_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (if_a.data_valid) hi_a <= hi_a + 1;
    if (if_a.data_valid && !dva_p)
      qa.push_back(rec_t'{cyc, 9'(if_a.data_out), if_a.parity_err, if_a.frame_err});
    if (if_b.data_valid && !dvb_p)
      qb.push_back(rec_t'{cyc, 9'(if_b.data_out), if_b.parity_err, if_b.frame_err});
    dva_p <= if_a.data_valid;
    dvb_p <= if_b.data_valid;
  end

  task automatic set_line(input int which, input logic b);
    if (which == 0) rx_a = b; else rx_b = b;
  endtask

  // Sends fr[0..n-1], one bit per BC cycles; the line keeps the last bit.
  task automatic drive(input int which, input logic [15:0] fr, input int n, output int t0);
    @(negedge clk);
    t0 = cyc;
    for (int i = 0; i < n; i++) begin
      set_line(which, fr[i]);
      repeat (BC) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1;
    if_a.data_ready = 1'b1; if_b.data_ready = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({if_a.data_out, if_a.data_valid, if_a.parity_err, if_a.frame_err, if_a.overrun} !== 13'd0) begin
      n_err++; $display("FAIL reset_a: got %h want 0",
        {if_a.data_out, if_a.data_valid, if_a.parity_err, if_a.frame_err, if_a.overrun});
    end
    n_vec++;
    if ({if_b.data_out, if_b.data_valid, if_b.parity_err, if_b.frame_err, if_b.overrun} !== 12'd0) begin
      n_err++; $display("FAIL reset_b: got %h want 0",
        {if_b.data_out, if_b.data_valid, if_b.parity_err, if_b.frame_err, if_b.overrun});
    end
    reset_n = 1'b1;
    repeat (40) @(negedge clk);
    n_vec++;
    if (qa.size() + qb.size() != 0) begin
      n_err++; $display("FAIL idle_after_reset: got %0d words want 0", qa.size() + qb.size());
    end
  endtask

  task automatic test_basic;
    int t0, h0;
    rec_t r;
    qa.delete(); h0 = hi_a;
    drive(0, 16'({1'b1, 8'hA5, 1'b0}), 10, t0);
    repeat (10) @(negedge clk);
    n_vec++;
    if (qa.size() != 1) begin
      n_err++; $display("FAIL basic_count: got %0d want 1", qa.size());
    end else begin
      r = qa[0];
      n_vec++;
      if (r.t != t0 + SYNC + LAT_A) begin
        n_err++; $display("FAIL basic_latency: got %0d want %0d", r.t - t0, SYNC + LAT_A);
      end
      n_vec++;
      if ({r.d, r.pe, r.fe} !== {9'h0A5, 2'b00}) begin
        n_err++; $display("FAIL basic_word: got %h/%b%b want a5/00", r.d, r.pe, r.fe);
      end
    end
    n_vec++;
    if (hi_a - h0 != 1) begin
      n_err++; $display("FAIL basic_pulse: got %0d cycles want 1", hi_a - h0);
    end
  endtask

  task automatic test_parity;
    int t0;
    logic [6:0] d;
    logic pb, exp_pe;
    rec_t r;
    qb.delete();
    d = 7'h41; pb = ~(^d);  // deliberately wrong even-parity bit
    exp_pe = (($countones({d, pb}) % 2) != 0);
    drive(1, 16'({2'b11, pb, d, 1'b0}), 11, t0);
    set_line(1, 1'b1);
    repeat (10) @(negedge clk);
    n_vec++;
    if (qb.size() != 1) begin
      n_err++; $display("FAIL parity_count: got %0d want 1", qb.size());
    end else begin
      r = qb[0];
      n_vec++;
      if ({r.t - t0, r.d, r.pe, r.fe} !== {SYNC + LAT_B, 9'h041, exp_pe, 1'b0}) begin
        n_err++; $display("FAIL parity_word: got lat %0d %h/%b%b want lat %0d 41/%b0",
          r.t - t0, r.d, r.pe, r.fe, SYNC + LAT_B, exp_pe);
      end
    end
  endtask

  task automatic test_glitch;
    qa.delete();
    @(negedge clk); rx_a = 1'b0;
    repeat (6) @(negedge clk); rx_a = 1'b1;
    repeat (200) @(negedge clk);
    n_vec++;
    if (qa.size() != 0 || if_a.data_valid !== 1'b0) begin
      n_err++; $display("FAIL glitch: got %0d words dv %b want 0", qa.size(), if_a.data_valid);
    end
  endtask

  task automatic test_frame_err;
    int t0;
    qa.delete();
    drive(0, 16'({1'b0, 8'h3C, 1'b0}), 10, t0);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    n_vec++;
    if (qa.size() != 1 || {qa[0].d, qa[0].pe, qa[0].fe} !== {9'h03C, 2'b01}) begin
      n_err++; $display("FAIL frame_err: got %0d words want one 3c with frame_err", qa.size());
    end
  endtask

  task automatic test_break;
    int t0;
    qa.delete();
    drive(0, 16'h0000, 10, t0);
    repeat (200) @(negedge clk);  // line held low past a whole frame time
    n_vec++;
    if (qa.size() != 1 || {qa[0].d, qa[0].fe} !== {9'h000, 1'b1}) begin
      n_err++; $display("FAIL break: got %0d words want one 00 with frame_err", qa.size());
    end
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    drive(0, 16'({1'b1, 8'h96, 1'b0}), 10, t0);
    repeat (10) @(negedge clk);
    n_vec++;
    if (qa.size() != 2 || {qa[1].d, qa[1].pe, qa[1].fe} !== {9'h096, 2'b00}) begin
      n_err++; $display("FAIL after_break: got %0d words want second 96 clean", qa.size());
    end
  endtask

  task automatic test_overrun;
    int t0;
    qa.delete();
    if_a.data_ready = 1'b0;
    drive(0, 16'({1'b1, 8'h11, 1'b0}), 10, t0);
    repeat (5) @(negedge clk);
    drive(0, 16'({1'b1, 8'h22, 1'b0}), 10, t0);
    repeat (10) @(negedge clk);
    n_vec++;
    if ({qa.size() == 1, if_a.data_out, if_a.data_valid, if_a.overrun} !== {1'b1, 8'h11, 2'b11}) begin
      n_err++; $display("FAIL overrun_hold: got %0d words out %h dv %b ov %b want 1 11 1 1",
        qa.size(), if_a.data_out, if_a.data_valid, if_a.overrun);
    end
    if_a.data_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({if_a.data_valid, if_a.overrun} !== 2'b00) begin
      n_err++; $display("FAIL overrun_clear: got dv %b ov %b want 0 0", if_a.data_valid, if_a.overrun);
    end
  endtask

  task automatic test_reset_mid;
    int t0;
    logic [7:0] d;
    qa.delete();
    d = 8'hC3;
    drive(0, 16'({d[3:0], 1'b0}), 5, t0);
    rx_a = d[4];
    repeat (5) @(negedge clk);
    reset_n = 1'b0; rx_a = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({if_a.data_out, if_a.data_valid, if_a.parity_err, if_a.frame_err, if_a.overrun} !== 13'd0) begin
      n_err++; $display("FAIL reset_mid: got %h want 0",
        {if_a.data_out, if_a.data_valid, if_a.parity_err, if_a.frame_err, if_a.overrun});
    end
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    n_vec++;
    if (qa.size() != 0) begin
      n_err++; $display("FAIL reset_mid_pulse: got %0d words want 0", qa.size());
    end
    drive(0, 16'({1'b1, 8'h5A, 1'b0}), 10, t0);
    repeat (10) @(negedge clk);
    n_vec++;
    if (qa.size() != 1 || {qa[0].t - t0, qa[0].d, qa[0].pe, qa[0].fe} !== {SYNC + LAT_A, 9'h05A, 2'b00}) begin
      n_err++; $display("FAIL reset_mid_next: got %0d words want one 5a", qa.size());
    end
  endtask

  task automatic test_random;
    int t0, which;
    logic [7:0] d;
    logic pb, s1, s2, exp_pe, exp_fe;
    rec_t r;
    for (int i = 0; i < 24; i++) begin
      which = i % 2;
      d = 8'($urandom);
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      qa.delete(); qb.delete();
      if (which == 0) begin
        exp_pe = 1'b0; exp_fe = ~s1;
        drive(0, 16'({s1, d, 1'b0}), 10, t0);
      end else begin
        d[7] = 1'b0;
        pb = ($urandom_range(0, 1) == 1);
        exp_pe = (($countones({d[6:0], pb}) % 2) != 0);
        exp_fe = ~(s1 & s2);
        drive(1, 16'({s2, s1, pb, d[6:0], 1'b0}), 11, t0);
      end
      set_line(which, 1'b1);
      repeat ($urandom_range(4, 20)) @(negedge clk);
      n_vec++;
      if ((which == 0 ? qa.size() : qb.size()) != 1) begin
        n_err++; $display("FAIL random_%0d_count: got %0d want 1", i, which == 0 ? qa.size() : qb.size());
      end else begin
        r = (which == 0) ? qa[0] : qb[0];
        n_vec++;
        if ({r.t - t0, r.d, r.pe, r.fe} !== {SYNC + (which == 0 ? LAT_A : LAT_B), {1'b0, d}, exp_pe, exp_fe}) begin
          n_err++; $display("FAIL random_%0d: got lat %0d %h/%b%b want lat %0d %h/%b%b", i,
            r.t - t0, r.d, r.pe, r.fe, SYNC + (which == 0 ? LAT_A : LAT_B), d, exp_pe, exp_fe);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_parity;
    test_glitch;
    test_frame_err;
    test_break;
    test_overrun;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
